// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_pkg
// Description : Shared definitions for the QPSK baseband modulator: sample
//               width, default constellation magnitude, pair-assembler
//               states and Gray encode/decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package qpsk_pkg;

  localparam int c_sample_w    = 7;
  localparam int c_default_amp = 45;

  // Pair assembler occupancy: no bits, s0 held, complete pair waiting
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } asm_state_t;

  // Binary phase index to Gray-coded dibit: 0->00, 1->01, 2->11, 3->10
  function automatic logic [1:0] gray_enc(input logic [1:0] bin);
    return {bin[1], bin[1] ^ bin[0]};
  endfunction

  // Gray-coded dibit to binary phase increment: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gray_dec(input logic [1:0] gray);
    return {gray[1], gray[1] ^ gray[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_symbol_map.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_symbol_map
// Description : Combinational dibit {s0,s1} to constellation point. s0 picks
//               the sign of the Q sample, s1 the sign of the I sample; a set
//               bit means the negative level.
// Revision    : 1.0 - initial release
// ============================================================================
module qpsk_symbol_map
  import qpsk_pkg::*;
#(
  parameter int AMP = c_default_amp
) (
  input  logic [1:0]                   i_dibit,
  output logic signed [c_sample_w-1:0] o_re,
  output logic signed [c_sample_w-1:0] o_im
);

  // AMP never exceeds 63, so both levels fit the signed sample width
  localparam logic signed [c_sample_w-1:0] c_pos = c_sample_w'(AMP);
  localparam logic signed [c_sample_w-1:0] c_neg = c_sample_w'(-AMP);

  assign o_im = i_dibit[1] ? c_neg : c_pos;
  assign o_re = i_dibit[0] ? c_neg : c_pos;

endmodule
`default_nettype wire

// File: rtl/qpsk_modulator_baseband.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_modulator_baseband
// Description : Serial bit stream to 7-bit signed I/Q QPSK samples. Bits are
//               paired, mapped to one of four points and each symbol is
//               presented for SPS beats under a valid/ready handshake.
//               Optional macro QPSK_DIFF_EN enables differential (Gray
//               phase-increment) encoding ahead of the mapper.
// Revision    : 1.0 - initial release
// ============================================================================
module qpsk_modulator_baseband
  import qpsk_pkg::*;
#(
  parameter int AMP = c_default_amp,
  parameter int SPS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_bit,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [c_sample_w-1:0] out_re,
  output logic signed [c_sample_w-1:0] out_im,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam logic [7:0] c_last_beat = 8'(SPS - 1);

  asm_state_t                   r_state;
  logic                         r_s0;
  logic [1:0]                   r_pair;
  logic                         r_out_valid;
  logic [7:0]                   r_beat;
  logic signed [c_sample_w-1:0] r_re;
  logic signed [c_sample_w-1:0] r_im;

  logic                         w_accept;
  logic                         w_pair_avail;
  logic                         w_can_load;
  logic                         w_load;
  logic [1:0]                   w_pair_dibit;
  logic [1:0]                   w_tx_dibit;
  logic signed [c_sample_w-1:0] w_map_re;
  logic signed [c_sample_w-1:0] w_map_im;

  assign in_ready = (r_state != FULL);
  assign w_accept = in_valid && in_ready;

  // A pair is available either already stored, or completing this cycle
  assign w_pair_avail = (r_state == FULL) || ((r_state == HALF) && w_accept);
  assign w_pair_dibit = (r_state == FULL) ? r_pair : {r_s0, in_bit};

  // The output stage is free when idle or when its final beat is consumed now
  assign w_can_load = !r_out_valid || (out_ready && (r_beat == c_last_beat));
  assign w_load     = w_can_load && w_pair_avail;

`ifdef QPSK_DIFF_EN
  logic [1:0] r_phase;
  logic [1:0] w_phase_next;

  assign w_phase_next = r_phase + gray_dec(w_pair_dibit);
  assign w_tx_dibit   = gray_enc(w_phase_next);

  // Accumulated phase advances only when a symbol actually leaves the assembler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 2'd0;
    end else if (w_load) begin
      r_phase <= w_phase_next;
    end
  end
`else
  assign w_tx_dibit = w_pair_dibit;
`endif

  qpsk_symbol_map #(
    .AMP (AMP)
  ) u_symbol_map (
    .i_dibit (w_tx_dibit),
    .o_re    (w_map_re),
    .o_im    (w_map_im)
  );

  // Pair assembler: collects s0 then s1, parks a pair when the output is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_s0    <= 1'b0;
      r_pair  <= 2'b00;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_s0    <= in_bit;
            r_state <= HALF;
          end
        end
        HALF: begin
          if (w_accept) begin
            r_pair  <= {r_s0, in_bit};
            r_state <= w_load ? EMPTY : FULL;
          end
        end
        FULL: begin
          if (w_load) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Output stage: load a new symbol, step through its beats, or go idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_beat      <= 8'd0;
      r_re        <= '0;
      r_im        <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_beat      <= 8'd0;
      r_re        <= w_map_re;
      r_im        <= w_map_im;
    end else if (r_out_valid && out_ready) begin
      if (r_beat < c_last_beat) begin
        r_beat <= r_beat + 8'd1;
      end else begin
        // Final beat consumed with nothing queued: samples return to zero
        r_out_valid <= 1'b0;
        r_beat      <= 8'd0;
        r_re        <= '0;
        r_im        <= '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_re    = r_re;
  assign out_im    = r_im;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_modulator_baseband.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_qpsk_modulator_baseband
// Description : Self-checking bench for qpsk_modulator_baseband. Instance A
//               runs with SPS = 1, instance B with SPS = 4. Expected symbols
//               are queued when a pair is accepted and compared beat by beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qpsk_modulator_baseband;

  localparam int SPS_B = 4;
  localparam logic [6:0] POS = 7'b0101101;  // +45
  localparam logic [6:0] NEG = 7'b1010011;  // -45

  logic clk = 1'b0;
  logic rst_n;

  logic              in_bit_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic signed [6:0] out_re_a, out_im_a;
  logic              in_bit_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic signed [6:0] out_re_b, out_im_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [13:0] sb_a[$];
  logic [13:0] sb_b[$];
  logic        half_a, s0_a, half_b, s0_b;
  logic [1:0]  ph_a, ph_b;
  logic [13:0] last_a, last_b;
  int          beats_b, total_b;

  qpsk_modulator_baseband #(.AMP(45), .SPS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .out_re(out_re_a), .out_im(out_im_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  qpsk_modulator_baseband #(.AMP(45), .SPS(SPS_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .out_re(out_re_b), .out_im(out_im_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference mapping: s0 selects the Q sign, s1 the I sign
  function automatic logic [13:0] sym_of(input logic [1:0] tx);
    logic [6:0] re, im;
    im = tx[1] ? NEG : POS;
    re = tx[0] ? NEG : POS;
    return {re, im};
  endfunction

  function automatic logic [1:0] inc_of(input logic [1:0] d);
    case (d)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] gray_of(input logic [1:0] p);
    case (p)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Drive one bit into A until accepted; queue the expected symbol on a pair
  task automatic send_bit_a(input logic b);
    int  n;
    bit  done;
    logic [1:0] tx;
    in_valid_a = 1'b1; in_bit_a = b; done = 0; n = 0;
    while (!done && n < 200) begin
      done = in_ready_a;
      @(posedge clk); #1; n++;
    end
    in_valid_a = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_a timeout: in_ready stayed %b, required 1", in_ready_a);
    end else if (!half_a) begin
      half_a = 1'b1; s0_a = b;
    end else begin
      half_a = 1'b0;
`ifdef QPSK_DIFF_EN
      ph_a = ph_a + inc_of({s0_a, b});
      tx   = gray_of(ph_a);
`else
      tx   = {s0_a, b};
`endif
      last_a = sym_of(tx);
      sb_a.push_back(last_a);
    end
  endtask

  task automatic send_bit_b(input logic b);
    int  n;
    bit  done;
    logic [1:0] tx;
    in_valid_b = 1'b1; in_bit_b = b; done = 0; n = 0;
    while (!done && n < 200) begin
      done = in_ready_b;
      @(posedge clk); #1; n++;
    end
    in_valid_b = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_b timeout: in_ready stayed %b, required 1", in_ready_b);
    end else if (!half_b) begin
      half_b = 1'b1; s0_b = b;
    end else begin
      half_b = 1'b0;
`ifdef QPSK_DIFF_EN
      ph_b = ph_b + inc_of({s0_b, b});
      tx   = gray_of(ph_b);
`else
      tx   = {s0_b, b};
`endif
      last_b = sym_of(tx);
      sb_b.push_back(last_b);
    end
  endtask

  // Scoreboard for A: every valid beat must match the oldest expected symbol
  always @(negedge clk) begin
    checks++;
    if (out_valid_a) begin
      if (sb_a.size() == 0) begin
        errors++;
        $display("FAIL sb_a extra beat: got re=%0d im=%0d, none expected", out_re_a, out_im_a);
      end else begin
        if ({out_re_a, out_im_a} !== sb_a[0]) begin
          errors++;
          $display("FAIL sb_a sample: got re=%0d im=%0d, required re=%0d im=%0d",
                   out_re_a, out_im_a, $signed(sb_a[0][13:7]), $signed(sb_a[0][6:0]));
        end
        if (out_ready_a) void'(sb_a.pop_front());
      end
    end else if (out_re_a !== 7'd0 || out_im_a !== 7'd0) begin
      errors++;
      $display("FAIL idle_a samples: got re=%0d im=%0d, required 0 0", out_re_a, out_im_a);
    end
  end

  // Scoreboard for B: each symbol must appear for exactly SPS_B consumed beats
  always @(negedge clk) begin
    checks++;
    if (out_valid_b) begin
      if (sb_b.size() == 0) begin
        errors++;
        $display("FAIL sb_b extra beat: got re=%0d im=%0d, none expected", out_re_b, out_im_b);
      end else begin
        if ({out_re_b, out_im_b} !== sb_b[0]) begin
          errors++;
          $display("FAIL sb_b sample beat %0d: got re=%0d im=%0d, required re=%0d im=%0d",
                   beats_b, out_re_b, out_im_b, $signed(sb_b[0][13:7]), $signed(sb_b[0][6:0]));
        end
        if (out_ready_b) begin
          beats_b++; total_b++;
          if (beats_b == SPS_B) begin
            beats_b = 0;
            void'(sb_b.pop_front());
          end
        end
      end
    end else if (out_re_b !== 7'd0 || out_im_b !== 7'd0) begin
      errors++;
      $display("FAIL idle_b samples: got re=%0d im=%0d, required 0 0", out_re_b, out_im_b);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: in_ready=%b out_valid=%b, required 1 0", in_ready_a, out_valid_a);
    end
    checks++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || out_re_b !== 7'd0 || out_im_b !== 7'd0) begin
      errors++;
      $display("FAIL reset_b: in_ready=%b out_valid=%b re=%0d im=%0d, required 1 0 0 0",
               in_ready_b, out_valid_b, out_re_b, out_im_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mapping();
    logic [1:0] pairs [4];
    pairs = '{2'b00, 2'b01, 2'b10, 2'b11};
    out_ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_bit_a(pairs[i][1]);
      send_bit_a(pairs[i][0]);
      checks++;
      if (out_valid_a !== 1'b1 || {out_re_a, out_im_a} !== last_a) begin
        errors++;
        $display("FAIL map_latency pair %b: valid=%b re=%0d im=%0d, required 1 re=%0d im=%0d",
                 pairs[i], out_valid_a, out_re_a, out_im_a,
                 $signed(last_a[13:7]), $signed(last_a[6:0]));
      end
`ifndef QPSK_DIFF_EN
      if (i == 0) begin
        checks++;
        if (out_re_a !== 7'b0101101 || out_im_a !== 7'b0101101) begin
          errors++;
          $display("FAIL map_00: got re=%0d im=%0d, required 45 45", out_re_a, out_im_a);
        end
      end
      if (i == 1) begin
        checks++;
        if (out_re_a !== 7'b1010011 || out_im_a !== 7'b0101101) begin
          errors++;
          $display("FAIL map_01: got re=%0d im=%0d, required -45 45", out_re_a, out_im_a);
        end
      end
`endif
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (sb_a.size() != 0) begin
      errors++;
      $display("FAIL map_drain: %0d symbols left, required 0", sb_a.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    out_ready_a = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 16; i++) send_bit_a(1'($urandom_range(0, 1)));
    checks++;
    if (cyc - t0 != 16) begin
      errors++;
      $display("FAIL b2b_rate: 16 bits took %0d cycles, required 16", cyc - t0);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (sb_a.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d symbols left, required 0", sb_a.size());
    end
  endtask

  task automatic test_stall();
    logic [13:0] held;
    out_ready_a = 1'b0;
    send_bit_a(1'b0);
    send_bit_a(1'b1);
    held = {out_re_a, out_im_a};
    fork
      begin
        send_bit_a(1'b1); send_bit_a(1'b0);
        send_bit_a(1'b1); send_bit_a(1'b1);
      end
      begin
        repeat (10) @(posedge clk); #1;
        checks++;
        if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || {out_re_a, out_im_a} !== held) begin
          errors++;
          $display("FAIL stall_hold: in_ready=%b valid=%b re=%0d im=%0d, required 0 1 re=%0d im=%0d",
                   in_ready_a, out_valid_a, out_re_a, out_im_a,
                   $signed(held[13:7]), $signed(held[6:0]));
        end
        out_ready_a = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    checks++;
    if (sb_a.size() != 0 || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: %0d left valid=%b, required 0 0", sb_a.size(), out_valid_a);
    end
  endtask

  task automatic test_sps4();
    int n;
    out_ready_b = 1'b1;
    total_b = 0;
    send_bit_b(1'b0); send_bit_b(1'b1);
    send_bit_b(1'b1); send_bit_b(1'b0);
    checks++;
    if (in_ready_b !== 1'b0 || out_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL sps4_full: in_ready=%b valid=%b, required 0 1", in_ready_b, out_valid_b);
    end
    n = 0;
    while (in_ready_b !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL sps4_reload: in_ready=%b valid=%b, required 1 1", in_ready_b, out_valid_b);
    end
    send_bit_b(1'b1); send_bit_b(1'b1);
    send_bit_b(1'b0); send_bit_b(1'b0);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (sb_b.size() != 0 || beats_b != 0 || total_b != 16) begin
      errors++;
      $display("FAIL sps4_beats: left=%0d partial=%0d total=%0d, required 0 0 16",
               sb_b.size(), beats_b, total_b);
    end
  endtask

  task automatic test_reset_mid();
    out_ready_a = 1'b0;
    send_bit_a(1'b0); send_bit_a(1'b0);
    send_bit_a(1'b1);
    rst_n = 1'b0;
    sb_a.delete(); half_a = 1'b0; ph_a = 2'd0;
    sb_b.delete(); half_b = 1'b0; ph_b = 2'd0; beats_b = 0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || out_re_a !== 7'd0 || out_im_a !== 7'd0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: valid=%b re=%0d im=%0d in_ready=%b, required 0 0 0 1",
               out_valid_a, out_re_a, out_im_a, in_ready_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    send_bit_a(1'b1); send_bit_a(1'b0);
    checks++;
    if (out_valid_a !== 1'b1 || {out_re_a, out_im_a} !== last_a) begin
      errors++;
      $display("FAIL rst_mid_pair: valid=%b re=%0d im=%0d, required 1 re=%0d im=%0d",
               out_valid_a, out_re_a, out_im_a, $signed(last_a[13:7]), $signed(last_a[6:0]));
    end
`ifndef QPSK_DIFF_EN
    checks++;
    if (out_re_a !== POS || out_im_a !== NEG) begin
      errors++;
      $display("FAIL rst_mid_10: got re=%0d im=%0d, required 45 -45", out_re_a, out_im_a);
    end
`endif
    repeat (3) @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_bit_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    in_bit_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    half_a = 1'b0; s0_a = 1'b0; half_b = 1'b0; s0_b = 1'b0;
    ph_a = 2'd0; ph_b = 2'd0; last_a = '0; last_b = '0;
    beats_b = 0; total_b = 0;
    test_reset();
    test_mapping();
    test_back_to_back();
    test_stall();
    test_sps4();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
